// File: rtl/shift_amt_unit.sv
// shift_amt_unit
// Multicycle shift/rotate unit with an integrated shift-amount source
// selector. On an accepted start it captures the operand, the amount and
// the operation, then shifts by up to STEP positions per cycle until the
// captured amount is used up. Completion is a single-cycle done pulse.
//
// Handshake: start is a request that is only looked at in IDLE. The
// operation is accepted on the rising edge where start=1 and the unit is
// in IDLE. busy is high for every SHIFT cycle. done is high for exactly
// one cycle (DONE) after the last shift step. busy and done are never high
// together. A start seen in SHIFT or DONE is dropped, never queued.
module shift_amt_unit #(
  parameter int WIDTH     = 32,
  parameter int STEP      = 1,
  parameter int CONST_AMT = 16,
  parameter int AMT_W     = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [1:0]       amt_sel,
  input  logic [WIDTH-1:0] amt_in_1,
  input  logic [WIDTH-1:0] amt_in_2,
  input  logic [WIDTH-1:0] amt_in_3,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] result,
  output logic [AMT_W-1:0] amt_out,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [2:0] MODE_SLL = 3'b000;
  localparam logic [2:0] MODE_SRL = 3'b001;
  localparam logic [2:0] MODE_SRA = 3'b010;
  localparam logic [2:0] MODE_ROL = 3'b011;
  localparam logic [2:0] MODE_ROR = 3'b100;

  // STEP may equal WIDTH, which needs one bit more than an amount.
  localparam logic [AMT_W:0]   STEP_V  = (AMT_W+1)'(STEP);
  localparam logic [AMT_W-1:0] CONST_V = AMT_W'(CONST_AMT);

  state_t             state;
  state_t             state_nxt;
  logic [2:0]         mode_q;
  logic [AMT_W-1:0]   cnt;
  logic [AMT_W-1:0]   sel_amt;
  logic [AMT_W-1:0]   accept_amt;
  logic [AMT_W:0]     cnt_ext;
  logic [AMT_W:0]     step_amt;
  logic               last_step;
  logic [2*WIDTH-1:0] rot_l;
  logic [2*WIDTH-1:0] rot_r;
  logic [WIDTH-1:0]   shifted;
  logic               accept;

  assign accept    = (state == ST_IDLE) && start;
  assign state_dbg = state;

  // Amount source selection; pass-through modes force the amount to zero.
  always_comb begin
    sel_amt = '0;
    case (amt_sel)
      2'b00:   sel_amt = amt_in_1[AMT_W-1:0];
      2'b01:   sel_amt = amt_in_2[AMT_W-1:0];
      2'b10:   sel_amt = amt_in_3[AMT_W-1:0];
      default: sel_amt = CONST_V;
    endcase
    accept_amt = (mode > MODE_ROR) ? '0 : sel_amt;
  end

  // Per-cycle step size s = min(STEP, cnt) and the last-step condition.
  always_comb begin
    cnt_ext   = {1'b0, cnt};
    last_step = (cnt_ext <= STEP_V);
    step_amt  = last_step ? cnt_ext : STEP_V;
  end

  // One step of the latched operation applied to the current result.
  // Rotations use a doubled copy so that a step of 0 needs no special case.
  always_comb begin
    rot_l   = {result, result} << step_amt;
    rot_r   = {result, result} >> step_amt;
    shifted = result;
    case (mode_q)
      MODE_SLL: shifted = result << step_amt;
      MODE_SRL: shifted = result >> step_amt;
      MODE_SRA: shifted = $signed(result) >>> step_amt;
      MODE_ROL: shifted = rot_l[2*WIDTH-1:WIDTH];
      MODE_ROR: shifted = rot_r[WIDTH-1:0];
      default:  shifted = result;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: the SHIFT step that consumes the last cnt goes to DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_SHIFT;
      ST_SHIFT: if (last_step) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Status outputs decoded from the state.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      ST_SHIFT: busy = 1'b1;
      ST_DONE:  done = 1'b1;
      default:  ;
    endcase
  end

  // Datapath: capture on accept, shift while in SHIFT, hold otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result  <= '0;
      amt_out <= '0;
      cnt     <= '0;
      mode_q  <= '0;
    end else if (accept) begin
      result  <= data_in;
      amt_out <= accept_amt;
      cnt     <= accept_amt;
      mode_q  <= mode;
    end else if (state == ST_SHIFT) begin
      result  <= shifted;
      cnt     <= cnt - step_amt[AMT_W-1:0];
    end
  end

  // Upper amount bits are ignored by definition; step_amt never exceeds cnt.
  logic unused_bits;
  assign unused_bits = ^{amt_in_1[WIDTH-1:AMT_W], amt_in_2[WIDTH-1:AMT_W],
                         amt_in_3[WIDTH-1:AMT_W], step_amt[AMT_W],
                         rot_l[WIDTH-1:0], rot_r[2*WIDTH-1:WIDTH]};

endmodule

// File: tb/tb_shift_amt_unit.sv
// Bench for shift_amt_unit: one STEP=1 and one STEP=4 instance sharing
// operand inputs, each with its own start. A bit-at-a-time reference model
// provides expected results, amounts and latencies.
module tb_shift_amt_unit;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start_1 = 1'b0;
  logic        start_4 = 1'b0;
  logic [2:0]  mode = '0;
  logic [1:0]  amt_sel = '0;
  logic [31:0] amt_in_1 = '0, amt_in_2 = '0, amt_in_3 = '0, data_in = '0;

  logic [31:0] result_1, result_4;
  logic [4:0]  amt_1, amt_4;
  logic        busy_1, busy_4, done_1, done_4;
  logic [1:0]  state_1, state_4;

  shift_amt_unit #(.WIDTH(32), .STEP(1), .CONST_AMT(16)) u_s1 (
    .clk(clk), .reset(rst_n), .start(start_1), .mode(mode), .amt_sel(amt_sel),
    .amt_in_1(amt_in_1), .amt_in_2(amt_in_2), .amt_in_3(amt_in_3),
    .data_in(data_in), .result(result_1), .amt_out(amt_1), .busy(busy_1),
    .done(done_1), .state_dbg(state_1));

  shift_amt_unit #(.WIDTH(32), .STEP(4), .CONST_AMT(16)) u_s4 (
    .clk(clk), .reset(rst_n), .start(start_4), .mode(mode), .amt_sel(amt_sel),
    .amt_in_1(amt_in_1), .amt_in_2(amt_in_2), .amt_in_3(amt_in_3),
    .data_in(data_in), .result(result_4), .amt_out(amt_4), .busy(busy_4),
    .done(done_4), .state_dbg(state_4));

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_shift(input logic [2:0] md, input logic [31:0] d, input int n);
    logic [31:0] r;
    r = d;
    for (int i = 0; i < n; i++) begin
      case (md)
        3'd0: r = {r[30:0], 1'b0};
        3'd1: r = {1'b0, r[31:1]};
        3'd2: r = {r[31], r[31:1]};
        3'd3: r = {r[30:0], r[31]};
        3'd4: r = {r[0], r[31:1]};
        default: r = r;
      endcase
    end
    return r;
  endfunction

  function automatic int ref_amt(input logic [2:0] md, input logic [1:0] sel,
                                 input logic [31:0] a1, input logic [31:0] a2, input logic [31:0] a3);
    int n;
    case (sel)
      2'd0: n = a1 % 32;
      2'd1: n = a2 % 32;
      2'd2: n = a3 % 32;
      default: n = 16;
    endcase
    if (md > 3'd4) n = 0;
    return n;
  endfunction

  function automatic int ref_cycles(input int n, input int step);
    if (n == 0) return 1;
    return (n + step - 1) / step;
  endfunction

  // ---------------- driver ----------------
  // Issues one operation and observes it; returns the observations.
  task automatic do_op(input bit use4, input logic [2:0] md, input logic [1:0] sel,
                       input logic [31:0] a1, input logic [31:0] a2, input logic [31:0] a3,
                       input logic [31:0] d,
                       output int busy_cyc, output int done_edge, output logic [31:0] res,
                       output logic [4:0] amt, output bit overlap, output logic done_after);
    @(negedge clk);
    mode = md; amt_sel = sel; amt_in_1 = a1; amt_in_2 = a2; amt_in_3 = a3; data_in = d;
    if (use4) start_4 = 1'b1; else start_1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_1 = 1'b0; start_4 = 1'b0;
    // scramble inputs after acceptance; they must have no effect
    mode = 3'($urandom); amt_sel = 2'($urandom); data_in = $urandom;
    busy_cyc = 0; done_edge = -1; overlap = 1'b0; res = '0; amt = '0; done_after = 1'bx;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if ((use4 ? busy_4 : busy_1) && (use4 ? done_4 : done_1)) overlap = 1'b1;
      if (use4 ? done_4 : done_1) begin
        done_edge = cyc;
        res = use4 ? result_4 : result_1;
        amt = use4 ? amt_4 : amt_1;
        break;
      end
      if (use4 ? busy_4 : busy_1) busy_cyc++;
      @(posedge clk);
      @(negedge clk);
    end
    if (done_edge >= 0) begin
      @(posedge clk);
      @(negedge clk);
      done_after = use4 ? done_4 : done_1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (result_1 !== 32'h0) begin bad++; $display("FAIL reset_result_1 got=%h exp=%h", result_1, 32'h0); end
    total++; if (amt_1 !== 5'd0) begin bad++; $display("FAIL reset_amt_1 got=%0d exp=0", amt_1); end
    total++; if (busy_1 !== 1'b0 || done_1 !== 1'b0) begin bad++; $display("FAIL reset_flags_1 got busy=%b done=%b exp 0 0", busy_1, done_1); end
    total++; if (state_1 !== 2'd0 || state_4 !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d/%0d exp=0/0", state_1, state_4); end
    total++; if (result_4 !== 32'h0 || amt_4 !== 5'd0 || busy_4 !== 1'b0 || done_4 !== 1'b0) begin
      bad++; $display("FAIL reset_s4 got res=%h amt=%0d busy=%b done=%b exp all 0", result_4, amt_4, busy_4, done_4); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (busy_1 !== 1'b0 || done_1 !== 1'b0 || result_1 !== 32'h0) begin
      bad++; $display("FAIL idle_after_reset got busy=%b done=%b res=%h exp 0 0 0", busy_1, done_1, result_1); end
  endtask

  task automatic test_plan_vectors();
    int bc, de; logic [31:0] r; logic [4:0] a; bit ov; logic da;
    do_op(1'b0, 3'd0, 2'd0, 32'd4, 32'd0, 32'd0, 32'h1, bc, de, r, a, ov, da);
    total++; if (r !== 32'h10 || a !== 5'd4) begin bad++; $display("FAIL sll4 got res=%h amt=%0d exp res=00000010 amt=4", r, a); end
    total++; if (de !== 4 || bc !== 4) begin bad++; $display("FAIL sll4_timing got done_edge=%0d busy=%0d exp 4 4", de, bc); end
    do_op(1'b0, 3'd2, 2'd3, 32'd0, 32'd0, 32'd0, 32'h8000_0000, bc, de, r, a, ov, da);
    total++; if (r !== 32'hFFFF_8000 || a !== 5'd16) begin bad++; $display("FAIL sra_const got res=%h amt=%0d exp res=ffff8000 amt=16", r, a); end
    total++; if (de !== 16 || da !== 1'b0) begin bad++; $display("FAIL sra_const_timing got done_edge=%0d done_after=%b exp 16 0", de, da); end
    do_op(1'b1, 3'd4, 2'd2, 32'd0, 32'd0, 32'h25, 32'hF1, bc, de, r, a, ov, da);
    total++; if (r !== 32'h8800_0007 || a !== 5'd5) begin bad++; $display("FAIL ror_step4 got res=%h amt=%0d exp res=88000007 amt=5", r, a); end
    total++; if (de !== 2 || bc !== 2 || ov !== 1'b0) begin bad++; $display("FAIL ror_step4_timing got done_edge=%0d busy=%0d ov=%b exp 2 2 0", de, bc, ov); end
  endtask

  task automatic test_zero_amount();
    int bc, de; logic [31:0] r; logic [4:0] a; bit ov; logic da;
    do_op(1'b0, 3'd0, 2'd1, 32'd0, 32'h20, 32'd0, 32'hDEAD_BEEF, bc, de, r, a, ov, da);
    total++; if (r !== 32'hDEAD_BEEF || a !== 5'd0 || de !== 1) begin
      bad++; $display("FAIL amt_zero got res=%h amt=%0d done_edge=%0d exp deadbeef 0 1", r, a, de); end
    do_op(1'b1, 3'd5, 2'd0, 32'd7, 32'd0, 32'd0, 32'hDEAD_BEEF, bc, de, r, a, ov, da);
    total++; if (r !== 32'hDEAD_BEEF || a !== 5'd0 || de !== 1 || bc !== 1) begin
      bad++; $display("FAIL passthru got res=%h amt=%0d done_edge=%0d busy=%0d exp deadbeef 0 1 1", r, a, de, bc); end
  endtask

  task automatic test_ignore_start();
    int de;
    // accept SLL by 3 of 1 on the STEP=1 unit
    @(negedge clk);
    mode = 3'd0; amt_sel = 2'd0; amt_in_1 = 32'd3; data_in = 32'h1; start_1 = 1'b1;
    @(posedge clk); @(negedge clk);                  // after edge 0
    start_1 = 1'b0; data_in = 32'hFFFF;
    @(posedge clk); @(negedge clk);                  // after edge 1
    start_1 = 1'b1; data_in = 32'hAAAA; amt_in_1 = 32'd9;
    @(posedge clk); @(negedge clk);                  // after edge 2, start seen in SHIFT
    start_1 = 1'b0; amt_in_1 = 32'd3;
    total++; if (busy_1 !== 1'b1 || amt_1 !== 5'd3) begin bad++; $display("FAIL start_in_shift got busy=%b amt=%0d exp 1 3", busy_1, amt_1); end
    de = -1;
    for (int i = 0; i < 20; i++) begin
      if (done_1) begin de = i; break; end
      @(posedge clk); @(negedge clk);
    end
    total++; if (de < 0 || result_1 !== 32'h8) begin bad++; $display("FAIL ignore_first_result got res=%h seen=%0d exp 00000008", result_1, de); end
    // start during DONE with different data: sampled in DONE, dropped
    start_1 = 1'b1; data_in = 32'h5555;
    @(posedge clk); @(negedge clk);
    start_1 = 1'b0;
    total++; if (busy_1 !== 1'b0 || done_1 !== 1'b0 || result_1 !== 32'h8) begin
      bad++; $display("FAIL start_in_done got busy=%b done=%b res=%h exp 0 0 00000008", busy_1, done_1, result_1); end
    // now in IDLE: the next start is accepted
    mode = 3'd0; amt_in_1 = 32'd1; data_in = 32'h2; start_1 = 1'b1;
    @(posedge clk); @(negedge clk);
    start_1 = 1'b0;
    total++; if (busy_1 !== 1'b1 || amt_1 !== 5'd1) begin bad++; $display("FAIL next_accept got busy=%b amt=%0d exp 1 1", busy_1, amt_1); end
    @(posedge clk); @(negedge clk);
    total++; if (done_1 !== 1'b1 || result_1 !== 32'h4) begin bad++; $display("FAIL next_result got done=%b res=%h exp 1 00000004", done_1, result_1); end
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit seen;
    @(negedge clk);
    mode = 3'd1; amt_sel = 2'd0; amt_in_1 = 32'd20; data_in = 32'hF000_0000; start_1 = 1'b1;
    @(posedge clk); @(negedge clk);
    start_1 = 1'b0;
    repeat (5) begin @(posedge clk); @(negedge clk); end
    rst_n = 1'b0;
    #1;
    total++; if (result_1 !== 32'h0 || busy_1 !== 1'b0 || done_1 !== 1'b0 || amt_1 !== 5'd0) begin
      bad++; $display("FAIL reset_mid got res=%h busy=%b done=%b amt=%0d exp 0 0 0 0", result_1, busy_1, done_1, amt_1); end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); @(negedge clk);
      if (done_1 || busy_1) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL no_done_after_reset got activity=%b exp 0", seen); end
  endtask

  task automatic test_random(input bit use4, input int n_ops);
    int bc, de, n, m; logic [31:0] r, e; logic [4:0] a; bit ov; logic da;
    logic [2:0] md; logic [1:0] sel; logic [31:0] a1, a2, a3, d;
    for (int k = 0; k < n_ops; k++) begin
      md = 3'($urandom_range(0, 7)); sel = 2'($urandom_range(0, 3));
      a1 = $urandom; a2 = $urandom; a3 = $urandom; d = $urandom;
      n = ref_amt(md, sel, a1, a2, a3);
      m = ref_cycles(n, use4 ? 4 : 1);
      exp_q.push_back(ref_shift(md, d, n));
      do_op(use4, md, sel, a1, a2, a3, d, bc, de, r, a, ov, da);
      e = exp_q.pop_front();
      total++; if (r !== e) begin bad++; $display("FAIL rand_result s%0d md=%0d n=%0d got=%h exp=%h", use4 ? 4 : 1, md, n, r, e); end
      total++; if (a !== 5'(n)) begin bad++; $display("FAIL rand_amt got=%0d exp=%0d", a, n); end
      total++; if (de !== m || bc !== m) begin bad++; $display("FAIL rand_timing n=%0d got done_edge=%0d busy=%0d exp %0d", n, de, bc, m); end
      total++; if (ov !== 1'b0 || da !== 1'b0) begin bad++; $display("FAIL rand_pulse got overlap=%b done_after=%b exp 0 0", ov, da); end
    end
  endtask

  initial begin
    test_reset();
    test_plan_vectors();
    test_zero_amount();
    test_ignore_start();
    test_reset_mid();
    test_random(1'b0, 40);
    test_random(1'b1, 40);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
